// File: rtl/tone_gen.sv
// tone_gen: square-wave note synthesiser with articulation gap, mute and volume.
// Optional macro TONE_GEN_STEREO_PAN_EN adds a pan input steering the sample left/right.
module tone_gen #(
    parameter int DIV_W      = 22,
    parameter int GAP_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [11:0]        ibeat,
    input  logic [DIV_W-1:0]   note_div,
    input  logic [2:0]         volume,
    input  logic               mute,
`ifdef TONE_GEN_STEREO_PAN_EN
    input  logic [1:0]         pan,
`endif
    output logic signed [15:0] audio_left,
    output logic signed [15:0] audio_right,
    output logic               note_on
);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    logic [11:0]        ibeat_q;
    logic [DIV_W-1:0]   div_q, cnt_q, cnt_d;
    logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
    logic               sq_q, sq_d;
    logic               div_change, beat_change, div_zero, gap_on, restart, wrap, silent;
    logic [15:0]        amp;
    logic signed [15:0] sample, left_d, right_d;

    always_comb begin
        div_change  = note_div != div_q;
        beat_change = ibeat != ibeat_q;
        div_zero    = note_div == '0;
        gap_on      = gap_cnt_q != '0;
        wrap        = cnt_q == note_div - DIV_W'(1);
        // A beat change only restarts the phase when it actually opens a gap
        restart     = div_change || div_zero || gap_on || (beat_change && GAP_CYCLES != 0);
        gap_cnt_d   = div_change                ? '0 :
                      (beat_change && !div_zero) ? GW'(GAP_CYCLES) :
                      gap_on                     ? gap_cnt_q - GW'(1) : '0;
        cnt_d       = (restart || wrap) ? '0 : cnt_q + DIV_W'(1);
        sq_d        = restart ? 1'b0 : (wrap ? ~sq_q : sq_q);
        silent      = mute || div_zero || gap_on || volume == '0;
        amp         = {1'b0, volume, 12'b0};
        sample      = silent ? '0 : (sq_q ? amp : -amp);
`ifdef TONE_GEN_STEREO_PAN_EN
        left_d      = (pan == 2'd2) ? '0 : sample;
        right_d     = (pan == 2'd1) ? '0 : sample;
`else
        left_d      = sample;
        right_d     = sample;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ibeat_q     <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            sq_q        <= 1'b0;
            gap_cnt_q   <= '0;
            audio_left  <= '0;
            audio_right <= '0;
            note_on     <= 1'b0;
        end else begin
            ibeat_q     <= ibeat;
            div_q       <= note_div;
            cnt_q       <= cnt_d;
            sq_q        <= sq_d;
            gap_cnt_q   <= gap_cnt_d;
            audio_left  <= left_d;
            audio_right <= right_d;
            note_on     <= !silent;
        end
    end
endmodule

// File: tb/tb_tone_gen.sv
// tb_tone_gen: randomized and directed check of tone_gen against a phase-arithmetic model.
module tb_tone_gen;
    localparam int GAP = 10;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [11:0]        ibeat = '0;
    logic [21:0]        note_div = '0;
    logic [2:0]         volume = '0;
    logic               mute = 1'b0;
    logic [1:0]         pan = '0;
    logic signed [15:0] audio_left, audio_right;
    logic               note_on;

    int vectors = 0;
    int miscompares = 0;

    tone_gen #(.DIV_W(22), .GAP_CYCLES(GAP)) dut (
        .clk(clk),
        .reset(reset),
        .ibeat(ibeat),
        .note_div(note_div),
        .volume(volume),
        .mute(mute),
`ifdef TONE_GEN_STEREO_PAN_EN
        .pan(pan),
`endif
        .audio_left(audio_left),
        .audio_right(audio_right),
        .note_on(note_on)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase is elapsed cycles since the note (re)started; the square level
    // is the parity of elapsed / half-period.
    int m_elapsed = 0, m_gap = 0, m_pdiv = 0, m_pbeat = 0;
    int e_l, e_r, e_on, s;
    bit m_sq, m_sil;

    always @(posedge clk) begin
        if (reset) begin
            e_l = 0; e_r = 0; e_on = 0;
            m_elapsed = 0; m_gap = 0; m_pdiv = 0; m_pbeat = 0;
        end else begin
            m_sq  = (m_pdiv != 0) && (((m_elapsed / m_pdiv) % 2) == 1);
            m_sil = mute || note_div == 0 || m_gap > 0 || volume == 0;
            s     = m_sil ? 0 : (m_sq ? 4096 * int'(volume) : -4096 * int'(volume));
            e_on  = m_sil ? 0 : 1;
            e_l   = s;
            e_r   = s;
`ifdef TONE_GEN_STEREO_PAN_EN
            if (pan == 2'd1) e_r = 0;
            if (pan == 2'd2) e_l = 0;
`endif
            if (int'(note_div) != m_pdiv) begin
                m_elapsed = 0; m_gap = 0;
            end else if (int'(ibeat) != m_pbeat && note_div != 0 && GAP > 0) begin
                m_elapsed = 0; m_gap = GAP;
            end else if (m_gap > 0) begin
                m_elapsed = 0; m_gap--;
            end else if (note_div == 0) begin
                m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
            m_pdiv  = int'(note_div);
            m_pbeat = int'(ibeat);
        end
        #1;
        chk("left", int'(audio_left), e_l);
        chk("right", int'(audio_right), e_r);
        chk("note_on", int'(note_on), e_on);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_left", int'(audio_left), 0);
        chk("rst_on", int'(note_on), 0);
        reset = 1'b0; note_div = 22'd4; volume = 3'd2; ibeat = 12'd3;
        // Reset phase lasts one extra sample, then 4-cycle half periods
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk("basic", int'(audio_left), k <= 5 ? -8192 : 8192);
            chk("basic_on", int'(note_on), 1);
        end
        repeat (3) @(negedge clk);
        ibeat = 12'd4;
        @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("gap", int'(audio_left), 0);
            chk("gap_on", int'(note_on), 0);
        end
        @(negedge clk);
        chk("gap_restart", int'(audio_left), -8192);
        repeat (2) @(negedge clk);
        ibeat = 12'd5; note_div = 22'd6;
        @(negedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("newdiv", int'(audio_left), k <= 6 ? -8192 : 8192);
        end
        note_div = 22'd4;
        repeat (5) @(negedge clk);
        mute = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("mute", int'(audio_left), 0);
        end
        mute = 1'b0;
        repeat (10) @(negedge clk);
        note_div = 22'd0; volume = 3'd7;
        repeat (3) @(negedge clk);
        chk("rest", int'(audio_left), 0);
        chk("rest_on", int'(note_on), 0);
        note_div = 22'd1;
        repeat (3) @(negedge clk);
        chk("div1_a", int'(audio_left), 28672);
        @(negedge clk);
        chk("div1_b", int'(audio_left), -28672);
        @(negedge clk);
        chk("div1_c", int'(audio_left), 28672);
`ifdef TONE_GEN_STEREO_PAN_EN
        pan = 2'd1; note_div = 22'd4; volume = 3'd1;
        repeat (4) @(negedge clk);
        chk("pan_l", int'(audio_left), -4096);
        chk("pan_r", int'(audio_right), 0);
        repeat (4) @(negedge clk);
        chk("pan_l2", int'(audio_left), 4096);
        chk("pan_r2", int'(audio_right), 0);
`endif
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            reset = $urandom_range(0, 299) == 0;
            if ($urandom_range(0, 24) == 0) ibeat = ibeat + 12'd1;
            if ($urandom_range(0, 39) == 0) note_div = 22'($urandom_range(0, 7));
            if ($urandom_range(0, 59) == 0) volume = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) mute = ~mute;
            if ($urandom_range(0, 49) == 0) pan = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tone_gen.md
TONE_GEN -- requirements
Module: tone_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 22: width of note_div and of the half-period counter.
REQ-002 SHALL have parameter GAP_CYCLES, default 1000000: length in clk cycles of the silent articulation gap; 0 disables the gap.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ibeat  input  12  current beat index from the beat counter; sampled every clk.
REQ-006 SHALL have port note_div  input  DIV_W  half-period of the current note in clk cycles; 0 means rest.
REQ-007 SHALL have port volume  input  3  amplitude step, 0-7.
REQ-008 SHALL have port mute  input  1  forces silent output without disturbing phase.
REQ-009 SHALL have port audio_left  output  16  signed two's-complement left sample, registered.
REQ-010 SHALL have port audio_right  output  16  signed two's-complement right sample, registered.
REQ-011 SHALL have port note_on  output  1  high while a non-silent tone is being emitted, registered.

Function
REQ-012 SHALL register ibeat_q and div_q each cycle; beat_change = (ibeat != ibeat_q) and div_change = (note_div != div_q).
REQ-013 SHALL, on div_change, set cnt to 0, sq to 0 and gap_cnt to 0, so the new note starts with reset phase and no gap.
REQ-014 SHALL, on beat_change with no div_change and note_div != 0, load gap_cnt with GAP_CYCLES, so repeated equal notes are separated.
REQ-015 SHALL, while gap_cnt != 0, decrement gap_cnt once per cycle and hold cnt = 0 and sq = 0.
REQ-016 SHALL, when note_div != 0, gap_cnt = 0 and no change event, advance cnt; at cnt == note_div-1 it SHALL set cnt to 0 and invert sq.
REQ-017 SHALL hold cnt = 0 and sq = 0 while note_div == 0.
REQ-018 SHALL treat note_div == 1 as toggling sq every cycle.
REQ-019 SHALL compute amp = volume * 4096, unsigned, range 0 to 28672.
REQ-020 SHALL define silent = mute OR note_div == 0 OR gap_cnt != 0 OR volume == 0, evaluated on the current registered state.
REQ-021 SHALL register audio_left = 0 when silent, else +amp when sq = 1 and -amp when sq = 0, with one cycle of latency from the sq state.
REQ-022 SHALL register note_on = NOT silent, aligned with audio_left.
REQ-023 SHALL keep cnt and sq running while mute is high, so unmuting resumes in phase.
REQ-024 SHALL let div_change take priority over beat_change when both occur in the same cycle.
REQ-025 SHALL sustain the note with no gap while ibeat holds a constant value, e.g. an end-of-song terminal beat.

Reset
REQ-026 SHALL, while reset is high at a clk edge, clear cnt, sq, gap_cnt, ibeat_q, div_q, audio_left, audio_right and note_on to 0.
REQ-027 SHALL treat reset asserted mid-note or mid-gap as an immediate abort, with no gap after release unless a new beat_change occurs.
REQ-028 SHALL treat the first cycle after reset with note_div != 0 as a div_change, since div_q is 0.

Configuration
REQ-029 SHALL support macro TONE_GEN_STEREO_PAN_EN.
REQ-030 SHALL, when TONE_GEN_STEREO_PAN_EN is defined, add input pan[1:0]:
- 0 or 3: audio_right = audio_left.
- 1: left only, audio_right = 0.
- 2: right only, audio_left = 0 and audio_right carries the sample.
- note_on is unaffected by pan.
REQ-031 SHALL, when TONE_GEN_STEREO_PAN_EN is undefined, omit the pan port and make audio_right always equal audio_left.

Verification
REQ-032 SHALL cover: reset, then note_div=4, volume=2, ibeat constant -> audio_left alternates -8192 and +8192 every 4 cycles; note_on=1.
REQ-033 SHALL cover: GAP_CYCLES=10, note_div=4 steady, ibeat 5->6 -> audio_left=0 and note_on=0 for 10 cycles, then the tone restarts at -amp.
REQ-034 SHALL cover: ibeat 6->7 and note_div 4->6 in the same cycle -> no gap, cnt resets, new half-period is 6 cycles.
REQ-035 SHALL cover: mute high for 7 cycles mid-note with note_div=4 -> output 0, and after release the sample sign matches an unmuted reference phase.
REQ-036 SHALL cover: note_div=0 with volume=7 -> audio_left=0 and note_on=0; then note_div=1 -> output toggles +/-28672 every cycle.
REQ-037 SHALL cover: with TONE_GEN_STEREO_PAN_EN defined and pan=1, note_div=4, volume=1 -> audio_left = +/-4096 and audio_right = 0.
